// File: rtl/cache_flush_ctrl_if.sv
// Bank maintenance bus: flush request/completion, core-request gating and the
// maintenance operation stream into the bank pipeline input mux.
interface cache_flush_ctrl_if #(
  parameter int CACHE_SIZE = 16384,
  parameter int LINE_SIZE  = 64,
  parameter int NUM_BANKS  = 1,
  parameter int NUM_WAYS   = 1
);
  localparam int LINE_SEL_BITS = $clog2(CACHE_SIZE / (LINE_SIZE * NUM_BANKS * NUM_WAYS));
  localparam int WAY_SEL_BITS  = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

  logic                     flush_valid;
  logic                     flush_ready;
  logic                     flush_done_valid;
  logic                     flush_done_ready;
  logic                     core_req_valid;
  logic                     core_req_ready;
  logic                     mshr_empty;
  logic                     pipe_ready;
  logic                     pipe_valid;
  logic                     pipe_init;
  logic                     pipe_flush;
  logic [LINE_SEL_BITS-1:0] pipe_line;
  logic [WAY_SEL_BITS-1:0]  pipe_way;
  logic                     busy;

  // Controller side.
  modport slave (
    input  flush_valid, flush_done_ready, core_req_valid, mshr_empty, pipe_ready,
    output flush_ready, flush_done_valid, core_req_ready,
    output pipe_valid, pipe_init, pipe_flush, pipe_line, pipe_way, busy
  );

  // Bank / requester side.
  modport master (
    output flush_valid, flush_done_ready, core_req_valid, mshr_empty, pipe_ready,
    input  flush_ready, flush_done_valid, core_req_ready,
    input  pipe_valid, pipe_init, pipe_flush, pipe_line, pipe_way, busy
  );
endinterface

// File: rtl/cache_flush_ctrl.sv
// Per-bank cache maintenance sequencer: init sweep after reset, flush sweep on request.
// Define CACHE_FLUSH_DRAIN_EN to make DRAIN wait for mshr_empty; otherwise DRAIN is one cycle.
module cache_flush_ctrl #(
  parameter int CACHE_SIZE = 16384,
  parameter int LINE_SIZE  = 64,
  parameter int NUM_BANKS  = 1,
  parameter int NUM_WAYS   = 1
) (
  input logic               clk,
  input logic               reset,
  cache_flush_ctrl_if.slave bus
);
  localparam int LINE_SEL_BITS = $clog2(CACHE_SIZE / (LINE_SIZE * NUM_BANKS * NUM_WAYS));
  localparam int WAY_SEL_BITS  = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
  localparam logic [WAY_SEL_BITS-1:0] LAST_WAY = WAY_SEL_BITS'(NUM_WAYS - 1);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_DRAIN,
    S_FLUSH,
    S_DONE
  } state_e;

  state_e                   state_q, state_d;
  logic [LINE_SEL_BITS-1:0] line_ctr_q, line_ctr_d;
  logic [WAY_SEL_BITS-1:0]  way_ctr_q, way_ctr_d;
  logic                     drain_exit;
  logic                     unused_in;

`ifdef CACHE_FLUSH_DRAIN_EN
  assign drain_exit = bus.mshr_empty;
  assign unused_in  = bus.core_req_valid;
`else
  assign drain_exit = 1'b1;
  assign unused_in  = bus.core_req_valid ^ bus.mshr_empty;
`endif

  // NOTE: every variable gets a default at the top of the block, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    line_ctr_d = line_ctr_q;
    way_ctr_d  = way_ctr_q;
    case (state_q)
      S_INIT: begin
        if (bus.pipe_ready) begin
          line_ctr_d = line_ctr_q + 1'b1;
          if (&line_ctr_q) state_d = S_IDLE;
        end
      end
      S_IDLE: begin
        if (bus.flush_valid) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (drain_exit) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        // Way-minor walk; the last (line, way) leaves both counters wrapped to 0.
        if (bus.pipe_ready) begin
          if (way_ctr_q == LAST_WAY) begin
            way_ctr_d  = '0;
            line_ctr_d = line_ctr_q + 1'b1;
            if (&line_ctr_q) state_d = S_DONE;
          end else begin
            way_ctr_d = way_ctr_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        if (bus.flush_done_ready) state_d = S_IDLE;
      end
      default: state_d = S_INIT;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments only; reset is synchronous and covers every flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_INIT;
      line_ctr_q <= '0;
      way_ctr_q  <= '0;
    end else begin
      state_q    <= state_d;
      line_ctr_q <= line_ctr_d;
      way_ctr_q  <= way_ctr_d;
    end
  end

  // Outputs decode the registered state; only core_req_ready sees an input (pipe_ready).
  always_comb begin
    bus.pipe_valid       = 1'b0;
    bus.pipe_init        = 1'b0;
    bus.pipe_flush       = 1'b0;
    bus.pipe_line        = '0;
    bus.pipe_way         = '0;
    bus.core_req_ready   = 1'b0;
    bus.flush_ready      = 1'b0;
    bus.flush_done_valid = 1'b0;
    bus.busy             = (state_q != S_IDLE);
    case (state_q)
      S_INIT: begin
        bus.pipe_valid = 1'b1;
        bus.pipe_init  = 1'b1;
        bus.pipe_line  = line_ctr_q;
      end
      S_IDLE: begin
        bus.core_req_ready = bus.pipe_ready;
        bus.flush_ready    = 1'b1;
      end
      S_FLUSH: begin
        bus.pipe_valid = 1'b1;
        bus.pipe_flush = 1'b1;
        bus.pipe_line  = line_ctr_q;
        bus.pipe_way   = way_ctr_q;
      end
      S_DONE: begin
        bus.flush_done_valid = 1'b1;
      end
      default: ;
    endcase
  end
endmodule
